// File: rtl/bram_axis_reader_if.sv
// BRAM read port plus AXI-Stream master bundle for bram_axis_reader, all channels
// flattened side by side. The master modport is the reader; the slave modport is BRAM/sink.
interface bram_axis_reader_if #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [CHANNELS-1:0]            bram_en;
  logic [CHANNELS*ADDR_WIDTH-1:0] bram_addr;
  logic [CHANNELS*DATA_WIDTH-1:0] bram_rddata;
  logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata;
  logic [CHANNELS-1:0]            m_axis_tvalid;
  logic [CHANNELS-1:0]            m_axis_tready;
  logic [CHANNELS-1:0]            m_axis_tlast;

  modport master (
    output bram_en, bram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  bram_rddata, m_axis_tready
  );

  modport slave (
    input  bram_en, bram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output bram_rddata, m_axis_tready
  );
endinterface

// File: rtl/bram_axis_reader.sv
// Multi-channel BRAM-to-AXI-Stream reader with credit-based prefetch FIFOs.
// Define BRAM_AXIS_READER_ABORT_EN to enable abort (flush + error); otherwise abort is ignored.
module bram_axis_reader #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned LEN_WIDTH    = 16,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [CHANNELS*ADDR_WIDTH-1:0]  base_addr,
  input  logic [CHANNELS*LEN_WIDTH-1:0]   length,
  bram_axis_reader_if.master              bus,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [CHANNELS-1:0]             err_chan
);

  localparam int unsigned OutW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StErr} state_e;

  state_e state_q;

  logic                           start_acc;
  logic                           run;
  logic [CHANNELS-1:0]            zero_len;
  logic [CHANNELS-1:0]            fin_vec;
  logic [CHANNELS-1:0]            last_hs;
  logic [CHANNELS-1:0]            en_vec;
  logic [CHANNELS-1:0]            tvalid_vec;
  logic [CHANNELS-1:0]            tlast_vec;
  logic [CHANNELS*ADDR_WIDTH-1:0] addr_vec;
  logic [CHANNELS*DATA_WIDTH-1:0] tdata_vec;

  assign start_acc = (state_q == StIdle) && start;
  assign run       = (state_q == StRun);

`ifdef BRAM_AXIS_READER_ABORT_EN
  logic flush;
  assign flush = run && abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issue_cnt_q;
    logic [LEN_WIDTH-1:0]  beat_cnt_q;
    logic [OutW-1:0]       outst_q;
    logic [OutW-1:0]       cnt_q;
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  fin_q;
    logic                  issue, push, pop, valid, last;

    // Outstanding counts in-flight reads plus FIFO entries, so the FIFO can never overflow.
    assign issue = run && (issue_cnt_q < len_q) && (outst_q < OutW'(FIFO_DEPTH));
    assign push  = vld_q[READ_LATENCY-1];
    assign valid = (cnt_q != '0);
    assign pop   = valid && bus.m_axis_tready[c];
    assign last  = valid && (beat_cnt_q == len_q - LEN_WIDTH'(1));

    assign zero_len[c]   = (length[c*LEN_WIDTH +: LEN_WIDTH] == '0);
    assign fin_vec[c]    = fin_q;
    assign last_hs[c]    = pop && last;
    assign en_vec[c]     = issue;
    assign tvalid_vec[c] = valid;
    assign tlast_vec[c]  = last;
    assign addr_vec[c*ADDR_WIDTH +: ADDR_WIDTH] = base_q + ADDR_WIDTH'(issue_cnt_q);
    assign tdata_vec[c*DATA_WIDTH +: DATA_WIDTH] = valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
      if (rst) begin
        base_q      <= '0;
        len_q       <= '0;
        issue_cnt_q <= '0;
        beat_cnt_q  <= '0;
        outst_q     <= '0;
        cnt_q       <= '0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        vld_q       <= '0;
        fin_q       <= 1'b0;
      end else if (start_acc) begin
        base_q      <= base_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        len_q       <= length[c*LEN_WIDTH +: LEN_WIDTH];
        issue_cnt_q <= '0;
        beat_cnt_q  <= '0;
        outst_q     <= '0;
        cnt_q       <= '0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        vld_q       <= '0;
        fin_q       <= 1'b0;
`ifdef BRAM_AXIS_READER_ABORT_EN
      end else if (flush) begin
        // Drop queued and in-flight data; late BRAM returns arrive untagged.
        outst_q  <= '0;
        cnt_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        vld_q    <= '0;
`endif
      end else begin
        if (issue) issue_cnt_q <= issue_cnt_q + LEN_WIDTH'(1);
        vld_q <= READ_LATENCY'({vld_q, issue});
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop) begin
          rd_ptr_q   <= ptr_inc(rd_ptr_q);
          beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
          if (last) fin_q <= 1'b1;
        end
        cnt_q   <= cnt_q + OutW'(push) - OutW'(pop);
        outst_q <= outst_q + OutW'(issue) - OutW'(pop);
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.bram_rddata[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.bram_en       = en_vec;
  assign bus.bram_addr     = addr_vec;
  assign bus.m_axis_tvalid = tvalid_vec;
  assign bus.m_axis_tlast  = tlast_vec;
  assign bus.m_axis_tdata  = tdata_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_chan <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy     <= 1'b1;
            err_chan <= zero_len;
            if (|zero_len) begin
              state_q <= StErr;
              error   <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
`ifdef BRAM_AXIS_READER_ABORT_EN
          if (abort) begin
            err_chan <= ~(fin_vec | last_hs);
            state_q  <= StErr;
            error    <= 1'b1;
          end else
`endif
          if (&(fin_vec | last_hs)) begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StDone, StErr: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_axis_reader.sv
// Scoreboard bench for bram_axis_reader: directed runs push expected addresses/beats,
// a negedge monitor pops and compares whenever the DUT issues a read or completes a beat.
module tb_bram_axis_reader;
  localparam int CH = 2;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int LW = 16;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [CH*AW-1:0] base_addr = '0;
  logic [CH*LW-1:0] length = '0;
  logic [CH-1:0]    tready = '1;
  logic             busy, done, error;
  logic [CH-1:0]    err_chan;

  bram_axis_reader_if #(.CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bram_axis_reader #(
    .CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .READ_LATENCY(RL), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .bus(bus),
    .busy(busy), .done(done), .error(error), .err_chan(err_chan)
  );

  always #5 clk = ~clk;

  // BRAM contents: channel tag in the top nibble, word address below.
  function automatic logic [DW-1:0] pat(input int c, input logic [AW-1:0] a);
    return {(c == 0) ? 4'hA : 4'hB, a};
  endfunction

  logic [DW-1:0] pipe [CH][RL];
  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (bus.bram_en[c]) pipe[c][0] <= pat(c, bus.bram_addr[c*AW +: AW]);
      for (int k = 1; k < RL; k++) pipe[c][k] <= pipe[c][k-1];
    end
  end
  assign bus.bram_rddata  = {pipe[1][RL-1], pipe[0][RL-1]};
  assign bus.m_axis_tready = tready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0;
  int last_cyc [CH];
  int outst_tb [CH];
  int max_outst [CH];
  logic [AW-1:0] addr_q [CH][$];
  logic [DW:0]   beat_q [CH][$];
  bit addr_chk = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected event", name);
  endtask

  initial begin : monitor
    logic [DW:0]   eb;
    logic [AW-1:0] ea;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (start && !busy) begin
          for (int c = 0; c < CH; c++) begin
            outst_tb[c]  = 0;
            max_outst[c] = 0;
          end
        end
        for (int c = 0; c < CH; c++) begin
          if (bus.bram_en[c]) begin
            outst_tb[c]++;
            if (addr_chk) begin
              if (addr_q[c].size() == 0) fail($sformatf("addr_extra_ch%0d", c));
              else begin
                ea = addr_q[c].pop_front();
                check($sformatf("addr_ch%0d", c), 32'(bus.bram_addr[c*AW +: AW]), 32'(ea));
              end
            end
          end
          if (bus.m_axis_tvalid[c] && tready[c]) begin
            outst_tb[c]--;
            if (beat_q[c].size() == 0) fail($sformatf("beat_extra_ch%0d", c));
            else begin
              eb = beat_q[c].pop_front();
              check($sformatf("tdata_ch%0d", c), 32'(bus.m_axis_tdata[c*DW +: DW]),
                    32'(eb[DW-1:0]));
              check($sformatf("tlast_ch%0d", c), 32'(bus.m_axis_tlast[c]), 32'(eb[DW]));
            end
            if (bus.m_axis_tlast[c]) last_cyc[c] = cyc;
          end
          if (outst_tb[c] > max_outst[c]) max_outst[c] = outst_tb[c];
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (error) err_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_run(input int c, input logic [AW-1:0] base, input int len,
                            input int nbeats);
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      addr_q[c].push_back(a);
      if (i < nbeats) beat_q[c].push_back({(i == len - 1), pat(c, a)});
    end
  endtask

  // Returns one cycle after the start-sampling edge (cycle 1).
  task automatic launch(input logic [AW-1:0] b0, input int l0, input logic [AW-1:0] b1,
                        input int l1);
    @(posedge clk);
    #1;
    base_addr = {b1, b0};
    length    = {LW'(l1), LW'(l0)};
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    int s = done_cnt + err_cnt;
    while ((done_cnt + err_cnt == s) && (n < budget)) begin
      step(1);
      n++;
    end
    if (n >= budget) fail("completion_timeout");
  endtask

  function automatic int left();
    return beat_q[0].size() + beat_q[1].size();
  endfunction

  initial begin
    int d, e;
    step(3);
    check("rst_bram_en", 32'(bus.bram_en), 0);
    check("rst_bram_addr", 32'(bus.bram_addr), 0);
    check("rst_tvalid", 32'(bus.m_axis_tvalid), 0);
    check("rst_tlast", 32'(bus.m_axis_tlast), 0);
    check("rst_tdata", 32'(bus.m_axis_tdata), 0);
    check("rst_status", 32'({busy, done, error, err_chan}), 0);
    rst = 1'b0;
    step(2);

    // Nominal run, plus a start pulse mid-run that must be ignored
    expect_run(0, 12'h010, 8, 8);
    expect_run(1, 12'h200, 8, 8);
    d = done_cnt;
    e = err_cnt;
    launch(12'h010, 8, 12'h200, 8);
    check("nom_busy_c1", 32'(busy), 1);
    check("nom_en_c1", 32'(bus.bram_en), 2'b11);
    step(2);
    check("nom_tvalid_c3", 32'(bus.m_axis_tvalid), 0);
    step(1);
    check("nom_tvalid_c4", 32'(bus.m_axis_tvalid), 2'b11);
    base_addr = {12'h700, 12'h700};
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_end(100);
    step(2);
    check("nom_done_pulses", done_cnt - d, 1);
    check("nom_no_error", err_cnt - e, 0);
    check("nom_beats_left", left(), 0);
    check("nom_busy_end", 32'(busy), 0);

    // Back-pressure: 20 stalled cycles mid-stream
    expect_run(0, 12'h020, 12, 12);
    expect_run(1, 12'h300, 12, 12);
    d = done_cnt;
    launch(12'h020, 12, 12'h300, 12);
    step(4);
    tready = '0;
    step(19);
    check("bp_tvalid_held", 32'(bus.m_axis_tvalid), 2'b11);
    step(1);
    tready = '1;
    wait_end(100);
    step(2);
    check("bp_max_outst_ch0", max_outst[0], 4);
    check("bp_max_outst_ch1", max_outst[1], 4);
    check("bp_beats_left", left(), 0);
    check("bp_done_pulses", done_cnt - d, 1);

    // Address wrap-around
    expect_run(0, 12'hFFE, 4, 4);
    expect_run(1, 12'h100, 2, 2);
    launch(12'hFFE, 4, 12'h100, 2);
    wait_end(60);
    step(2);
    check("wrap_beats_left", left(), 0);
    check("wrap_addr_left", addr_q[0].size() + addr_q[1].size(), 0);

    // Zero length on channel 1
    e = err_cnt;
    launch(12'h040, 5, 12'h050, 0);
    check("zl_error_c1", 32'(error), 1);
    check("zl_err_chan_c1", 32'(err_chan), 2'b10);
    check("zl_en_c1", 32'(bus.bram_en), 0);
    step(1);
    check("zl_busy_c2", 32'(busy), 0);
    check("zl_error_c2", 32'(error), 0);
    check("zl_err_chan_sticky", 32'(err_chan), 2'b10);
    step(3);
    check("zl_err_pulses", err_cnt - e, 1);

    // Unequal lengths 1 and 5
    expect_run(0, 12'h400, 1, 1);
    expect_run(1, 12'h500, 5, 5);
    d = done_cnt;
    launch(12'h400, 1, 12'h500, 5);
    check("uneq_err_chan_clr", 32'(err_chan), 0);
    wait_end(60);
    step(2);
    check("uneq_done_after_ch1", done_cyc, last_cyc[1] + 1);
    check("uneq_ch0_first", 32'(last_cyc[0] < last_cyc[1]), 1);
    check("uneq_done_pulses", done_cnt - d, 1);
    check("uneq_beats_left", left(), 0);

    // Reset mid-transfer
    tready   = '0;
    addr_chk = 1'b0;
    launch(12'h010, 8, 12'h200, 8);
    step(5);
    rst = 1'b1;
    step(1);
    check("mrst_tvalid", 32'(bus.m_axis_tvalid), 0);
    check("mrst_busy_en", 32'({busy, bus.bram_en}), 0);
    rst      = 1'b0;
    tready   = '1;
    addr_chk = 1'b1;
    step(2);

`ifdef BRAM_AXIS_READER_ABORT_EN
    // Abort during beat 3 of 10
    expect_run(0, 12'h600, 10, 4);
    expect_run(1, 12'h700, 10, 4);
    addr_chk = 1'b0;
    e = err_cnt;
    launch(12'h600, 10, 12'h700, 10);
    step(6);
    check("ab_tvalid_c7", 32'(bus.m_axis_tvalid), 2'b11);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("ab_tvalid_drop", 32'(bus.m_axis_tvalid), 0);
    check("ab_error", 32'(error), 1);
    check("ab_err_chan", 32'(err_chan), 2'b11);
    check("ab_en_drop", 32'(bus.bram_en), 0);
    step(2);
    check("ab_busy_end", 32'(busy), 0);
    check("ab_beats_left", left(), 0);
    check("ab_err_pulses", err_cnt - e, 1);
    addr_q[0].delete();
    addr_q[1].delete();
    addr_chk = 1'b1;
    expect_run(0, 12'h010, 3, 3);
    expect_run(1, 12'h020, 3, 3);
    d = done_cnt;
    launch(12'h010, 3, 12'h020, 3);
    check("ab_next_err_chan", 32'(err_chan), 0);
    wait_end(60);
    step(2);
    check("ab_next_done", done_cnt - d, 1);
    check("ab_next_beats_left", left(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/bram_axis_reader.md
# bram_axis_reader

Multi-channel BRAM-to-AXI-Stream read engine that feeds the KAN datapath with data, grid or scale vectors. On a start command it streams a programmable-length block from each channel's BRAM, starting at a programmable base address. Each channel has its own credit-based prefetch FIFO, so the stream runs at full rate through a fixed BRAM read latency and stalls safely on downstream back-pressure. Global busy/done/error status drives the interrupt logic.

## Interface
- CHANNELS, 2: independent BRAM/stream channel pairs.
- ADDR_WIDTH, 12: BRAM word-address width.
- DATA_WIDTH, 16: BRAM word and tdata width.
- LEN_WIDTH, 16: transfer-length width, in beats.
- READ_LATENCY, 2: cycles from bram_en to valid bram_rddata; must be 1..4.
- FIFO_DEPTH, 4: per-channel prefetch entries; must be at least READ_LATENCY+2.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- abort  in  1  cancel the running transfer (see Configuration).
- base_addr  in  CHANNELS*ADDR_WIDTH  per-channel start address.
- length  in  CHANNELS*LEN_WIDTH  per-channel beat count.
- bram_en  out  CHANNELS  read enable.
- bram_addr  out  CHANNELS*ADDR_WIDTH  read address.
- bram_rddata  in  CHANNELS*DATA_WIDTH  read data.
- m_axis_tdata  out  CHANNELS*DATA_WIDTH  stream data.
- m_axis_tvalid  out  CHANNELS  stream valid.
- m_axis_tready  in  CHANNELS  stream ready.
- m_axis_tlast  out  CHANNELS  final beat of the channel's block.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle error pulse.
- err_chan  out  CHANNELS  channels at fault; sticky until the next accepted start.

## Operation
- Global FSM states: IDLE, RUN, DONE, ERR.
- IDLE, start=1:
  - Latch base_addr and length. Clear err_chan.
  - If any length is 0: set the matching err_chan bits and go to ERR.
  - Otherwise go to RUN.
- RUN, per channel:
  - The issue counter i runs 0..length-1. bram_addr = base + i, modulo 2^ADDR_WIDTH (wrap-around is legal).
  - bram_en is asserted when i < length and outstanding < FIFO_DEPTH.
  - outstanding = reads in flight + FIFO occupancy. It increments on issue and decrements on an AXIS handshake; both in the same cycle leave it unchanged.
  - A READ_LATENCY-deep valid shift register tags returning data, which is written into the FIFO.
  - The FIFO head drives tdata and tvalid. tlast = 1 on beat index length-1.
  - The channel is finished when its tlast beat completes a handshake.
- When all channels are finished: go to DONE for one cycle (done=1), then IDLE.
- ERR: error=1 for one cycle, then IDLE.
- start while not in IDLE is ignored.
- Reset mid-transfer: all FIFOs, counters and shift registers clear; the FSM returns to IDLE.
- Reset values: bram_en=0, bram_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, error=0, err_chan=0.

## Timing
- start sampled at cycle 0:
  - busy=1 and the first bram_en at cycle 1.
  - Data enters the FIFO at cycle 1+READ_LATENCY.
  - First tvalid at cycle 2+READ_LATENCY (cycle 4 at default).
- Throughput is 1 beat per cycle per channel while tready=1.
- busy deasserts in the cycle after the DONE/ERR state.
- tvalid, once asserted, is held with stable tdata and tlast until the handshake.
- Bubble-free throughput holds with FIFO_DEPTH >= READ_LATENCY+2; credits guarantee no FIFO overflow with tready=0 for any duration.

## Configuration
- Macro BRAM_AXIS_READER_ABORT_EN.
- Defined: abort=1 in RUN takes effect in the next cycle:
  - bram_en and tvalid drop, FIFOs flush and in-flight data is discarded.
  - err_chan is set for every unfinished channel.
  - The FSM goes to ERR.
- Undefined: the abort port is present but ignored, and no flush logic is synthesised.

## Test plan
- Nominal run: CHANNELS=2, lengths 8/8, bases 0x010/0x200, tready=1 → 8 beats each, sequential addresses, tlast on beat 7, done pulse once, first tvalid at cycle 4.
- Address wrap: base 0xFFE, length 4 → addresses 0xFFE, 0xFFF, 0x000, 0x001 in order.
- Back-pressure: tready=0 for 20 cycles mid-stream → at most 4 reads outstanding, no data loss or duplication, stream resumes in order.
- Zero length: channel 1 length 0 → error pulse at cycle 1, err_chan=2'b10, no bram_en, busy low from cycle 2.
- Unequal lengths: lengths 1 and 5 → channel 0 tlast on its first beat; done only after channel 1's fifth beat.
- Abort (macro defined): abort at beat 3 of 10 → tvalid low the next cycle, error pulse, err_chan=2'b11; the next start runs normally.
